// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and the
// alignment rule used to reject a request before it touches memory.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD    = 3'd1,
    LD    = 3'd2,
    MERGE = 3'd3,
    WR    = 3'd4,
    ERR   = 3'd5
  } lsu_state_e;

  // Size 11 is treated as misaligned so that all bad requests share one path.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = off[0];
      SZ_WORD: bad = (off != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: extracts and extends a sub-word load, and merges
// sub-word store data into the word read back from RAM.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [1:0]   size_i,
  input  logic         unsigned_i,
  input  logic [1:0]   off_i,
  input  logic [N-1:0] rdata_i,
  input  logic [N-1:0] wdata_i,
  output logic [N-1:0] load_data_o,
  output logic [N-1:0] merge_data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        sign_bit;

  always_comb begin
    byte_sel    = rdata_i[{off_i, 3'b000} +: 8];
    half_sel    = rdata_i[{off_i[1], 4'b0000} +: 16];
    sign_bit    = 1'b0;
    load_data_o = rdata_i;
    case (size_i)
      SZ_BYTE: begin
        sign_bit    = byte_sel[7] & ~unsigned_i;
        load_data_o = {{(N-8){sign_bit}}, byte_sel};
      end
      SZ_HALF: begin
        sign_bit    = half_sel[15] & ~unsigned_i;
        load_data_o = {{(N-16){sign_bit}}, half_sel};
      end
      default: load_data_o = rdata_i;
    endcase
  end

  // Only the addressed lane is replaced; every other byte keeps RAM contents.
  always_comb begin
    merge_data_o = rdata_i;
    case (size_i)
      SZ_BYTE: merge_data_o[{off_i, 3'b000} +: 8]     = wdata_i[7:0];
      SZ_HALF: merge_data_o[{off_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      default: merge_data_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit in front of a word RAM with registered
// read data; sub-word stores are done as read-modify-write.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int n = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_write,
  input  logic [1:0]   req_size,
  input  logic         req_unsigned,
  input  logic [n-1:0] req_addr,
  input  logic [n-1:0] req_wdata,
  output logic         resp_valid,
  output logic [n-1:0] resp_rdata,
  output logic         resp_err,
  output logic         mem_we,
  output logic [n-1:0] mem_addr,
  output logic [n-1:0] mem_wdata,
  input  logic [n-1:0] mem_rdata,
  output lsu_state_e   dbg_state
);

  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // all req_* fields are captured on that edge, and resp_valid is a single-cycle
  // pulse that never back-pressures.

  lsu_state_e     state_q, state_d;
  logic [n-1:0]   addr_q, addr_d;
  logic [n-1:0]   wdata_q, wdata_d;
  logic [1:0]     size_q, size_d;
  logic           write_q, write_d;
  logic           unsigned_q, unsigned_d;

  logic           ready_c, resp_valid_c, resp_err_c, we_c;
  logic [n-1:0]   rdata_c, wdata_c;
  logic [n-1:0]   load_data, merge_data;

  lsu_align #(.N(n)) u_align (
    .size_i       (size_q),
    .unsigned_i   (unsigned_q),
    .off_i        (addr_q[1:0]),
    .rdata_i      (mem_rdata),
    .wdata_i      (wdata_q),
    .load_data_o  (load_data),
    .merge_data_o (merge_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      size_q     <= SZ_BYTE;
      write_q    <= 1'b0;
      unsigned_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      size_q     <= size_d;
      write_q    <= write_d;
      unsigned_q <= unsigned_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    size_d       = size_q;
    write_d      = write_q;
    unsigned_d   = unsigned_q;
    ready_c      = 1'b0;
    resp_valid_c = 1'b0;
    resp_err_c   = 1'b0;
    rdata_c      = '0;
    we_c         = 1'b0;
    wdata_c      = '0;
    case (state_q)
      IDLE: begin
        ready_c = 1'b1;
        if (req_valid) begin
          addr_d     = req_addr;
          wdata_d    = req_wdata;
          size_d     = req_size;
          write_d    = req_write;
          unsigned_d = req_unsigned;
          if (is_misaligned(req_size, req_addr[1:0])) begin
            state_d = ERR;
          end else if (req_write && (req_size == SZ_WORD)) begin
            state_d = WR;
          end else begin
            state_d = RD;
          end
        end
      end
      RD: begin
        state_d = write_q ? MERGE : LD;
      end
      LD: begin
        resp_valid_c = 1'b1;
        rdata_c      = load_data;
        state_d      = IDLE;
      end
      MERGE: begin
        we_c         = 1'b1;
        wdata_c      = merge_data;
        resp_valid_c = 1'b1;
        state_d      = IDLE;
      end
      WR: begin
        we_c         = 1'b1;
        wdata_c      = wdata_q;
        resp_valid_c = 1'b1;
        state_d      = IDLE;
      end
      ERR: begin
        resp_valid_c = 1'b1;
        resp_err_c   = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Gating with reset keeps a reset edge from committing a write or a response.
  assign req_ready  = ready_c & ~reset;
  assign resp_valid = resp_valid_c & ~reset;
  assign resp_err   = resp_err_c & ~reset;
  assign resp_rdata = reset ? '0 : rdata_c;
  assign mem_we     = we_c & ~reset;
  assign mem_wdata  = wdata_c;
  assign mem_addr   = {2'b00, addr_q[n-1:2]};
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural word RAM that has
// registered read data.
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic         req_write = 1'b0;
  logic [1:0]   req_size = 2'b00;
  logic         req_unsigned = 1'b0;
  logic [N-1:0] req_addr = '0;
  logic [N-1:0] req_wdata = '0;
  logic         resp_valid;
  logic [N-1:0] resp_rdata;
  logic         resp_err;
  logic         mem_we;
  logic [N-1:0] mem_addr;
  logic [N-1:0] mem_wdata;
  logic [N-1:0] mem_rdata;
  lsu_state_e   dbg_state;

  logic [N-1:0] ram [0:63];
  int           wr_cnt = 0;
  int           cyc = 0;
  int           checks = 0;
  int           failures = 0;

  logic [N-1:0] exp_q[$];
  int           lat_q[$];
  int           pres_q[$];
  logic         err_q[$];

  load_store_unit #(.n(N)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .dbg_state    (dbg_state)
  );

  // Clock / RAM model
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_we) begin
      ram[mem_addr[5:0]] <= mem_wdata;
      wr_cnt = wr_cnt + 1;
    end else begin
      mem_rdata <= ram[mem_addr[5:0]];
    end
  end

  task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=0x%08h exp=0x%08h", tag, obs, exp);
    end
  endtask

  // Issues one request, then waits for its response (bounded).
  task automatic do_req(input logic w, input logic [1:0] sz, input logic uns,
                        input logic [N-1:0] a, input logic [N-1:0] d,
                        output int lat, output logic [N-1:0] rd, output logic err,
                        output logic [N-1:0] maddr, output logic we_at_resp);
    int guard;
    logic got;
    guard = 0;
    got = 1'b0;
    lat = 0;
    rd = '0;
    err = 1'b0;
    maddr = '0;
    we_at_resp = 1'b0;
    @(negedge clk);
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    req_write = w;
    req_size = sz;
    req_unsigned = uns;
    req_addr = a;
    req_wdata = d;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    while (!got && lat < 10) begin
      @(negedge clk);
      lat++;
      if (resp_valid) begin
        got = 1'b1;
        rd = resp_rdata;
        err = resp_err;
        maddr = mem_addr;
        we_at_resp = mem_we;
      end
    end
    check("resp_seen", {31'd0, got}, 32'd1);
  endtask

  initial begin
    int lat;
    logic [N-1:0] rd, maddr;
    logic err, we_r;
    int w0;
    logic seen;
    int idx, nresp, last_resp_cyc;
    logic [N-1:0] vec_a [3];
    logic [N-1:0] vec_d [3];
    logic         vec_w [3];
    logic [1:0]   vec_s [3];
    logic [N-1:0] vec_exp [3];
    int           vec_lat [3];
    logic         vec_err [3];

    for (int i = 0; i < 64; i++) ram[i] = '0;
    ram[1] = 32'h0102_0304;

    // Reset block
    repeat (3) @(negedge clk);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_err", {31'd0, resp_err}, 32'd0);

    // Word store then word load
    do_req(1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEAD_BEEF, lat, rd, err, maddr, we_r);
    check("sw_lat", lat, 1);
    check("sw_err", {31'd0, err}, 32'd0);
    check("sw_addr", maddr, 32'd4);
    check("sw_we", {31'd0, we_r}, 32'd1);
    @(negedge clk);
    check("sw_ram", ram[4], 32'hDEAD_BEEF);
    do_req(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, lat, rd, err, maddr, we_r);
    check("lw_lat", lat, 2);
    check("lw_data", rd, 32'hDEAD_BEEF);
    check("lw_err", {31'd0, err}, 32'd0);
    check("lw_addr", maddr, 32'd4);

    // Sub-word loads with extension
    ram[4] = 32'h80FF_7F01;
    do_req(1'b0, SZ_BYTE, 1'b0, 32'h13, 32'h0, lat, rd, err, maddr, we_r);
    check("lb_s13", rd, 32'hFFFF_FF80);
    check("lb_lat", lat, 2);
    do_req(1'b0, SZ_BYTE, 1'b1, 32'h13, 32'h0, lat, rd, err, maddr, we_r);
    check("lbu_13", rd, 32'h0000_0080);
    do_req(1'b0, SZ_BYTE, 1'b0, 32'h12, 32'h0, lat, rd, err, maddr, we_r);
    check("lb_s12", rd, 32'hFFFF_FFFF);
    do_req(1'b0, SZ_BYTE, 1'b0, 32'h11, 32'h0, lat, rd, err, maddr, we_r);
    check("lb_s11", rd, 32'h0000_007F);
    do_req(1'b0, SZ_HALF, 1'b0, 32'h10, 32'h0, lat, rd, err, maddr, we_r);
    check("lh_s10", rd, 32'h0000_7F01);
    do_req(1'b0, SZ_HALF, 1'b0, 32'h12, 32'h0, lat, rd, err, maddr, we_r);
    check("lh_s12", rd, 32'hFFFF_80FF);
    do_req(1'b0, SZ_HALF, 1'b1, 32'h12, 32'h0, lat, rd, err, maddr, we_r);
    check("lhu_12", rd, 32'h0000_80FF);

    // Read-modify-write stores
    ram[8] = 32'h1122_3344;
    w0 = wr_cnt;
    do_req(1'b1, SZ_HALF, 1'b0, 32'h22, 32'h0000_ABCD, lat, rd, err, maddr, we_r);
    check("sh_lat", lat, 2);
    check("sh_we_merge", {31'd0, we_r}, 32'd1);
    check("sh_rdata", rd, 32'd0);
    @(negedge clk);
    check("sh_ram", ram[8], 32'hABCD_3344);
    check("sh_pulses", wr_cnt - w0, 1);
    do_req(1'b1, SZ_BYTE, 1'b0, 32'h21, 32'hFFFF_FF55, lat, rd, err, maddr, we_r);
    @(negedge clk);
    check("sb_ram", ram[8], 32'hABCD_5544);

    // Misaligned and illegal-size requests
    w0 = wr_cnt;
    do_req(1'b0, SZ_WORD, 1'b0, 32'h06, 32'h0, lat, rd, err, maddr, we_r);
    check("mis_w_lat", lat, 1);
    check("mis_w_err", {31'd0, err}, 32'd1);
    check("mis_w_rdata", rd, 32'd0);
    check("mis_w_we", {31'd0, we_r}, 32'd0);
    do_req(1'b0, SZ_HALF, 1'b0, 32'h05, 32'h0, lat, rd, err, maddr, we_r);
    check("mis_h_lat", lat, 1);
    check("mis_h_err", {31'd0, err}, 32'd1);
    do_req(1'b1, 2'b11, 1'b0, 32'h04, 32'hFFFF_FFFF, lat, rd, err, maddr, we_r);
    check("sz11_err", {31'd0, err}, 32'd1);
    @(negedge clk);
    check("mis_ram", ram[1], 32'h0102_0304);
    check("mis_pulses", wr_cnt - w0, 0);

    // Reset in the MERGE cycle of a byte store
    ram[12] = 32'hCAFE_F00D;
    w0 = wr_cnt;
    @(negedge clk);
    req_write = 1'b1;
    req_size = SZ_BYTE;
    req_unsigned = 1'b0;
    req_addr = 32'h31;
    req_wdata = 32'h77;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("rm_rd_we", {31'd0, mem_we}, 32'd0);
    @(negedge clk);
    check("rm_merge_we", {31'd0, mem_we}, 32'd1);
    reset = 1'b1;
    #1;
    check("rm_gate_we", {31'd0, mem_we}, 32'd0);
    check("rm_gate_rv", {31'd0, resp_valid}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rm_ready", {31'd0, req_ready}, 32'd1);
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (resp_valid) seen = 1'b1;
    end
    check("rm_no_resp", {31'd0, seen}, 32'd0);
    check("rm_ram", ram[12], 32'hCAFE_F00D);
    check("rm_pulses", wr_cnt - w0, 0);

    // Back-to-back stream with req_valid held high
    vec_w[0] = 1'b1; vec_s[0] = SZ_WORD; vec_a[0] = 32'h40; vec_d[0] = 32'h1234_5678;
    vec_exp[0] = 32'h0; vec_lat[0] = 1; vec_err[0] = 1'b0;
    vec_w[1] = 1'b0; vec_s[1] = SZ_WORD; vec_a[1] = 32'h40; vec_d[1] = 32'h0;
    vec_exp[1] = 32'h1234_5678; vec_lat[1] = 2; vec_err[1] = 1'b0;
    vec_w[2] = 1'b0; vec_s[2] = SZ_HALF; vec_a[2] = 32'h41; vec_d[2] = 32'h0;
    vec_exp[2] = 32'h0; vec_lat[2] = 1; vec_err[2] = 1'b1;
    idx = 0;
    nresp = 0;
    last_resp_cyc = -1;
    for (int c = 0; c < 40 && nresp < 3; c++) begin
      @(negedge clk);
      if (resp_valid) begin
        check("s_rdata", resp_rdata, exp_q.pop_front());
        check("s_err", {31'd0, resp_err}, {31'd0, err_q.pop_front()});
        check("s_lat", cyc - pres_q.pop_front(), lat_q.pop_front());
        last_resp_cyc = cyc;
        nresp++;
      end
      if (req_ready && idx < 3) begin
        if (last_resp_cyc >= 0) check("s_gap", cyc - last_resp_cyc, 1);
        req_write = vec_w[idx];
        req_size = vec_s[idx];
        req_unsigned = 1'b0;
        req_addr = vec_a[idx];
        req_wdata = vec_d[idx];
        req_valid = 1'b1;
        exp_q.push_back(vec_exp[idx]);
        lat_q.push_back(vec_lat[idx]);
        err_q.push_back(vec_err[idx]);
        pres_q.push_back(cyc);
        idx++;
      end else if (idx == 3) begin
        req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    check("s_nresp", nresp, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter n, default 32, SHALL set the data and byte-address width.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-004 req_valid  input  1  SHALL be the CPU request strobe.
REQ-005 req_ready  output  1  SHALL indicate the unit can accept a request.
REQ-006 req_write  input  1  SHALL select store (1) or load (0).
REQ-007 req_size  input  2  SHALL encode size: 00 byte, 01 half, 10 word; 11 is an error.
REQ-008 req_unsigned  input  1  SHALL select zero-extension (1) or sign-extension (0) for loads.
REQ-009 req_addr  input  n  SHALL be the byte address.
REQ-010 req_wdata  input  n  SHALL be the store data, right-aligned.
REQ-011 resp_valid  output  1  SHALL be a one-cycle completion pulse.
REQ-012 resp_rdata  output  n  SHALL be the extended load data, valid with resp_valid.
REQ-013 resp_err  output  1  SHALL flag misaligned or illegal-size requests, valid with resp_valid.
REQ-014 mem_we  output  1  SHALL be the write enable to the word RAM.
REQ-015 mem_addr  output  n  SHALL be the word index {2'b00, addr[n-1:2]}.
REQ-016 mem_wdata  output  n  SHALL be the full word written.
REQ-017 mem_rdata  input  n  SHALL be the RAM's registered read data, valid one cycle after a non-write cycle.

Function
REQ-018 A request SHALL be accepted on a rising edge where req_valid && req_ready; all req_* fields latch then.
REQ-019 req_ready SHALL be 1 only in IDLE; there SHALL be one outstanding request.
REQ-020 States SHALL be IDLE, RD, LD, MERGE, WR, ERR.
REQ-021 IDLE on acceptance SHALL go to ERR if the request is misaligned or illegal, WR for word stores, and RD otherwise.
REQ-022 Misaligned SHALL mean half with addr[0]=1, word with addr[1:0]!=0, or size 11.
REQ-023 RD SHALL drive mem_we=0 and mem_addr, then go to LD for loads and MERGE for stores.
REQ-024 LD SHALL assert resp_valid and drive resp_rdata from mem_rdata at byte lane addr[1:0] (byte) or half lane addr[1] (half), extended per req_unsigned, then go to IDLE.
REQ-025 MERGE SHALL drive mem_we=1 with mem_wdata equal to mem_rdata with only the addressed byte or half replaced by the low bits of req_wdata, assert resp_valid, then go to IDLE.
REQ-026 WR SHALL drive mem_we=1 and mem_wdata=req_wdata, assert resp_valid, then go to IDLE.
REQ-027 ERR SHALL assert resp_valid with resp_err=1 and resp_rdata=0, perform no memory access, then go to IDLE.
REQ-028 Latency from the accept edge to resp_valid SHALL be 1 cycle for word stores and errors, and 2 cycles for loads and sub-word stores.
REQ-029 resp_err SHALL be 0 and resp_rdata SHALL be 0 whenever they are not in the LD or ERR cases above.
REQ-030 A request SHALL be accepted in the cycle after resp_valid at the earliest, with no back-to-back bubble beyond this.
REQ-031 mem_we SHALL be 0 in every state other than WR and MERGE.

Reset
REQ-032 reset SHALL force IDLE, clear latched request fields, and drive resp_valid=0, resp_err=0, resp_rdata=0 and mem_we=0.
REQ-033 mem_we SHALL be gated by !reset, so no RAM write occurs at a reset edge, including mid-WR or mid-MERGE.
REQ-034 An in-flight request SHALL be dropped on reset with no response; req_ready SHALL be 1 in the first cycle after reset deasserts.

Structure
REQ-035 Package lsu_pkg SHALL hold the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the state enumeration.
REQ-036 Sub-module lsu_align SHALL be purely combinational and provide load extract/extend and store merge.
REQ-037 The block SHALL connect directly to the existing word RAM with no glue logic.

Verification
REQ-038 Word store 0xDEADBEEF @0x10, then word load @0x10 -> mem_addr=4; resp_rdata=0xDEADBEEF with resp_err=0; latencies 1 and 2 cycles.
REQ-039 Signed byte load @0x13 of word 0x80FF7F01 -> resp_rdata=0xFFFFFF80; unsigned -> 0x00000080.
REQ-040 Half store 0xABCD @0x22 over word 0x11223344 -> RAM word becomes 0xABCD3344; only one write pulse occurs, in the MERGE cycle.
REQ-041 Word load @0x06 and half load @0x05 -> resp_err=1 after 1 cycle, mem_we=0, and no RAM change.
REQ-042 Reset asserted during MERGE of a byte store -> RAM unchanged, no resp_valid, and req_ready=1 after release.
REQ-043 req_valid held high continuously over 3 mixed requests -> each is accepted only in IDLE, and responses are in order with exact latencies.
